// File: rtl/arbitro_balance_if.sv
// Bundle of the ATM front-end side signals of the shared balance arbiter:
// load port, per-requester request/op strobes, grant and status pulses.
interface arbitro_balance_if #(
    parameter int BAL_W   = 64,
    parameter int MONTO_W = 32
);
    logic                   load_stb;
    logic [BAL_W-1:0]       load_val;
    logic [1:0]             req;
    logic [1:0]             done;
    logic [1:0]             op_stb;
    logic [1:0]             op_tipo;
    logic [2*MONTO_W-1:0]   monto;
    logic [1:0]             gnt;
    logic [BAL_W-1:0]       balance;
    logic                   balance_actualizado;
    logic                   entregar_dinero;
    logic                   fondos_insuficientes;
    logic                   desborde;
    logic                   timeout_err;

    modport master (
        output load_stb, load_val, req, done, op_stb, op_tipo, monto,
        input  gnt, balance, balance_actualizado, entregar_dinero,
               fondos_insuficientes, desborde, timeout_err
    );

    modport slave (
        input  load_stb, load_val, req, done, op_stb, op_tipo, monto,
        output gnt, balance, balance_actualizado, entregar_dinero,
               fondos_insuficientes, desborde, timeout_err
    );
endinterface

// File: rtl/arbitro_balance.sv
// Round-robin owner arbitration for two cajero front ends sharing one balance
// register; only the owner may deposit/withdraw, a watchdog frees a hung owner.
module arbitro_balance #(
    parameter int               BAL_W         = 64,
    parameter int               MONTO_W       = 32,
    parameter int               TIMEOUT       = 16,
    parameter logic [BAL_W-1:0] BALANCE_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    arbitro_balance_if.slave  bus_io
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    localparam int               TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic             act_q, act_d;
    logic             ent_q, ent_d;
    logic             fondos_q, fondos_d;
    logic             desb_q, desb_d;
    logic             tout_q, tout_d;

    logic               own_op;
    logic               own_done;
    logic               own_tipo;
    logic [MONTO_W-1:0] monto_sel;
    logic [BAL_W-1:0]   monto_ext;
    logic [BAL_W:0]     sum;

    assign own_op    = bus_io.op_stb[owner_q];
    assign own_done  = bus_io.done[owner_q];
    assign own_tipo  = bus_io.op_tipo[owner_q];
    assign monto_sel = owner_q ? bus_io.monto[2*MONTO_W-1:MONTO_W] : bus_io.monto[MONTO_W-1:0];
    assign monto_ext = {{(BAL_W-MONTO_W){1'b0}}, monto_sel};
    // Extra carry bit flags a deposit that would wrap the balance.
    assign sum       = {1'b0, balance_q} + {1'b0, monto_ext};

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        timer_d   = timer_q;
        balance_d = balance_q;
        act_d     = 1'b0;
        ent_d     = 1'b0;
        fondos_d  = 1'b0;
        desb_d    = 1'b0;
        tout_d    = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                if (bus_io.load_stb) begin
                    balance_d = bus_io.load_val;
                end
                if (|bus_io.req) begin
                    state_d = BUSY;
                    owner_d = (bus_io.req == 2'b11) ? ~last_q : bus_io.req[1];
                    last_d  = owner_d;
                    timer_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (own_op) begin
                    timer_d = '0;
                    if (!own_tipo) begin
                        if (sum[BAL_W]) begin
                            desb_d = 1'b1;
                        end else begin
                            balance_d = sum[BAL_W-1:0];
                            act_d     = 1'b1;
                        end
                    end else if (monto_ext > balance_q) begin
                        fondos_d = 1'b1;
                    end else begin
                        balance_d = balance_q - monto_ext;
                        act_d     = 1'b1;
                        ent_d     = 1'b1;
                    end
                end
                // An owner op or done in the final watchdog cycle pre-empts the timeout.
                if (own_done) begin
                    state_d = RELEASE;
                end else if (!own_op) begin
                    if (timer_q == TMR_LAST) begin
                        state_d = RELEASE;
                        tout_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            timer_q   <= '0;
            balance_q <= BALANCE_RESET;
            act_q     <= 1'b0;
            ent_q     <= 1'b0;
            fondos_q  <= 1'b0;
            desb_q    <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            balance_q <= balance_d;
            act_q     <= act_d;
            ent_q     <= ent_d;
            fondos_q  <= fondos_d;
            desb_q    <= desb_d;
            tout_q    <= tout_d;
        end
    end

    assign bus_io.gnt                  = (state_q == BUSY) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus_io.balance              = balance_q;
    assign bus_io.balance_actualizado  = act_q;
    assign bus_io.entregar_dinero      = ent_q;
    assign bus_io.fondos_insuficientes = fondos_q;
    assign bus_io.desborde             = desb_q;
    assign bus_io.timeout_err          = tout_q;
endmodule

// File: tb/tb_arbitro_balance.sv
// Directed bench for arbitro_balance: load, deposits/withdrawals, alternation,
// watchdog release, overflow and asynchronous reset with hand-computed results.
module tb_arbitro_balance;
    logic clk;
    logic rst_n;
    int   compareCount;
    int   mismatchCount;

    arbitro_balance_if #(.BAL_W(64), .MONTO_W(32)) bus ();

    arbitro_balance #(
        .BAL_W(64), .MONTO_W(32), .TIMEOUT(16), .BALANCE_RESET(64'd0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] done,
                                 input logic [1:0] opStb, input logic [1:0] opTipo,
                                 input logic [31:0] monto1, input logic [31:0] monto0);
        bus.req     = req;
        bus.done    = done;
        bus.op_stb  = opStb;
        bus.op_tipo = opTipo;
        bus.monto   = {monto1, monto0};
    endtask

    task automatic idleInputs();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        bus.load_stb = 1'b0;
        bus.load_val = 64'd0;
    endtask

    task automatic checkPulses(input string tag, input logic [4:0] expected);
        checkOutput(tag, {59'd0, bus.balance_actualizado, bus.entregar_dinero,
                          bus.fondos_insuficientes, bus.desborde, bus.timeout_err},
                    {59'd0, expected});
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        idleInputs();
        doReset();
        checkOutput("reset_gnt", {62'd0, bus.gnt}, 64'd0);
        checkOutput("reset_balance", bus.balance, 64'd0);
        checkPulses("reset_pulses", 5'b00000);

        // T1: load, grant 0, deposit, release
        bus.load_stb = 1'b1; bus.load_val = 64'd1000;
        tick();
        bus.load_stb = 1'b0;
        checkOutput("t1_load", bus.balance, 64'd1000);
        checkPulses("t1_load_nopulse", 5'b00000);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("t1_gnt", {62'd0, bus.gnt}, 64'd1);
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 32'd0, 32'd250);
        tick();
        checkOutput("t1_dep_balance", bus.balance, 64'd1250);
        checkPulses("t1_dep_pulse", 5'b10000);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        checkPulses("t1_pulse_clear", 5'b00000);
        checkOutput("t1_release_gnt", {62'd0, bus.gnt}, 64'd0);
        idleInputs();
        tick();
        checkOutput("t1_idle_gnt", {62'd0, bus.gnt}, 64'd0);

        // T2: insufficient funds, then exact withdrawal
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("t2_gnt", {62'd0, bus.gnt}, 64'd1);
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b01, 32'd0, 32'd1300);
        tick();
        checkOutput("t2_nsf_balance", bus.balance, 64'd1250);
        checkPulses("t2_nsf_pulse", 5'b00100);
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b01, 32'd0, 32'd1250);
        tick();
        checkOutput("t2_wd_balance", bus.balance, 64'd0);
        checkPulses("t2_wd_pulse", 5'b11000);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        idleInputs();
        tick();

        // T3: alternation under contention
        doReset();
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("t3_first_gnt", {62'd0, bus.gnt}, 64'd1);
        applyStimulus(2'b11, 2'b01, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("t3_gap", {62'd0, bus.gnt}, 64'd0);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("t3_second_gnt", {62'd0, bus.gnt}, 64'd2);
        applyStimulus(2'b11, 2'b10, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("t3_gap2", {62'd0, bus.gnt}, 64'd0);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("t3_third_gnt", {62'd0, bus.gnt}, 64'd1);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        idleInputs();
        tick();

        // T4: non-owner op and BUSY load ignored, then watchdog
        bus.load_stb = 1'b1; bus.load_val = 64'd500;
        tick();
        bus.load_stb = 1'b0;
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("t4_gnt", {62'd0, bus.gnt}, 64'd1);
        applyStimulus(2'b10, 2'b10, 2'b10, 2'b00, 32'd77, 32'd0);
        bus.load_stb = 1'b1; bus.load_val = 64'd999;
        tick();
        bus.load_stb = 1'b0;
        checkOutput("t4_ignored_balance", bus.balance, 64'd500);
        checkPulses("t4_ignored_pulse", 5'b00000);
        checkOutput("t4_still_owner", {62'd0, bus.gnt}, 64'd1);
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("t4_pre_timeout_gnt", {62'd0, bus.gnt}, 64'd1);
        checkPulses("t4_pre_timeout_pulse", 5'b00000);
        tick();
        checkOutput("t4_timeout_gnt", {62'd0, bus.gnt}, 64'd0);
        checkPulses("t4_timeout_pulse", 5'b00001);
        tick();
        checkOutput("t4_handoff_gnt", {62'd0, bus.gnt}, 64'd2);
        checkPulses("t4_timeout_clear", 5'b00000);
        applyStimulus(2'b00, 2'b10, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        idleInputs();
        tick();

        // T5: overflow boundary
        bus.load_stb = 1'b1; bus.load_val = 64'hFFFF_FFFF_FFFF_FFF6;
        tick();
        bus.load_stb = 1'b0;
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 32'd0, 32'd10);
        tick();
        checkOutput("t5_ovf_balance", bus.balance, 64'hFFFF_FFFF_FFFF_FFF6);
        checkPulses("t5_ovf_pulse", 5'b00010);
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 32'd0, 32'd9);
        tick();
        checkOutput("t5_max_balance", bus.balance, 64'hFFFF_FFFF_FFFF_FFFF);
        checkPulses("t5_max_pulse", 5'b10000);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        idleInputs();
        tick();

        // T6: op and done together, then async reset mid-ownership
        bus.load_stb = 1'b1; bus.load_val = 64'd100;
        tick();
        bus.load_stb = 1'b0;
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        applyStimulus(2'b00, 2'b01, 2'b01, 2'b00, 32'd0, 32'd7);
        tick();
        checkOutput("t6_opdone_balance", bus.balance, 64'd107);
        checkPulses("t6_opdone_pulse", 5'b10000);
        checkOutput("t6_opdone_gnt", {62'd0, bus.gnt}, 64'd0);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("t6_regrant", {62'd0, bus.gnt}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_gnt", {62'd0, bus.gnt}, 64'd0);
        checkOutput("t6_async_balance", bus.balance, 64'd0);
        idleInputs();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("t6_after_reset_gnt", {62'd0, bus.gnt}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
